bsg_chip_mem_fwd_merge: RTL and testbench
=========================================

# bsg_chip_mem_fwd_merge

Merges the two BedRock stream memory ports of the single-core chip (port 0 = I$, port 1 = D$) onto one downstream memory channel and steers responses back to the originating port. It sits directly downstream of `bsg_chip`'s `mem_fwd_*` / `mem_rev_*` buses and upstream of the off-chip memory link. Arbitration is per message: a granted multi-beat stream is never interleaved. Response routing relies on the downstream memory answering in request order, tracked by a small source-ID FIFO.

## Interface
- `header_width_p`, 64: BedRock mem header width; matches `mem_fwd_header_width_lp` and `mem_rev_header_width_lp`.
- `data_width_p`, 64: stream beat data width; matches `bedrock_fill_width_p`.
- `els_p`, 4: maximum outstanding messages; power of two, 2 or more.
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `in_fwd_header_i` / `in_fwd_data_i`  in  [1:0][header_width_p] / [1:0][data_width_p]  per-port request beat.
- `in_fwd_v_i`, `in_fwd_last_i`  in  [1:0]  beat valid, last beat of message.
- `in_fwd_ready_and_o`  out  [1:0]  per-port ready.
- `in_rev_header_o` / `in_rev_data_o`  out  [1:0][...]  response beat broadcast to both ports.
- `in_rev_v_o`, `in_rev_last_o`  out  [1:0]  per-port response valid and last.
- `in_rev_ready_and_i`  in  [1:0]  per-port response ready.
- `out_fwd_header_o`, `out_fwd_data_o`, `out_fwd_v_o`, `out_fwd_last_o`  out  merged request.
- `out_fwd_ready_and_i`  in  1
- `out_rev_header_i`, `out_rev_data_i`, `out_rev_v_i`, `out_rev_last_i`  in  merged response.
- `out_rev_ready_and_o`  out  1
- `err_o`  out  1  sticky: a response arrived with no outstanding request.

## Operation
- Arbiter FSM states: IDLE and LOCKED(src).
  - IDLE: when at least one `in_fwd_v_i` is set and the FIFO is not full, grant a winner.
  - A first beat that is accepted without last moves the FSM to LOCKED(src).
  - LOCKED(src) forwards only port src. An accepted beat with last returns the FSM to IDLE.
- Round-robin: the priority pointer flips to the non-winner after each message is granted. The reset pointer favours port 0.
- The FIFO pushes the source ID (1 bit) when the first beat of a message is accepted downstream.
- FIFO full blocks a new grant in IDLE, including in a cycle with a simultaneous pop. It never stalls a LOCKED message.
- Response path: the FIFO head selects the destination port.
  - `in_rev_v_o[head] = out_rev_v_i`; `out_rev_ready_and_o = in_rev_ready_and_i[head]`.
  - The FIFO pops on an accepted beat with `out_rev_last_i`.
- FIFO empty with `out_rev_v_i` set: `out_rev_ready_and_o` is 1, the beat is discarded, and `err_o` is set. It stays set until reset.
- The FIFO occupancy counter is `$clog2(els_p)+1` bits. Read and write pointers wrap modulo `els_p`.

## Timing
- Forward and response paths are combinational: zero-cycle latency, valid/ready-and handshake.
- `out_fwd_v_o` never depends on `out_fwd_ready_and_i`.
- Under reset and on the first cycle after release, all of these are 0:
  - `out_fwd_v_o`, `in_fwd_ready_and_o`, `in_rev_v_o`, `out_rev_ready_and_o`.
  - FSM in IDLE, FIFO empty, `err_o` low.
- Reset mid-message discards the lock and all FIFO contents. The next message starts fresh in IDLE.

## Configuration
- `BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN`
  - Defined: fixed priority, port 1 (D$) always wins in IDLE. The round-robin pointer is not instantiated.
  - Undefined: round-robin as described under Operation.

## Test plan
- Both ports request 1-beat reads every cycle with downstream always ready: grants alternate 0,1,0,1, and responses return to 0,1,0,1 in order.
- Port 0 sends a 4-beat write while port 1 is valid throughout: the 4 port-0 beats are contiguous, then port 1 is granted in the cycle after port 0's last beat.
- `els_p`=4, responses withheld, 6 requests issued: exactly 4 are accepted and `in_fwd_ready_and_o` stays 0. Releasing one response lets the 5th request through the next cycle.
- Response for port 1 with `in_rev_ready_and_i[1]`=0 for 3 cycles: `out_rev_ready_and_o` stays 0 and the beat is held. Port 0 sees no valid.
- Inject a response with no requests outstanding: it is consumed in 1 cycle and `err_o` goes high and stays high. Asserting `reset_n_i` low clears it.
- With `BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN` defined and both ports continuously valid: port 1 wins every message and port 0 starves.

Source files
------------

// File: rtl/bsg_chip_mem_fwd_merge_if.sv
// Request/response bundle between the two BedRock stream ports, the merge and the memory link.
// master: chip side and memory model; slave: the merge block.
interface bsg_chip_mem_fwd_merge_if #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64
);
    logic [1:0][header_width_p-1:0] in_fwd_header_i;
    logic [1:0][data_width_p-1:0]   in_fwd_data_i;
    logic [1:0]                     in_fwd_v_i;
    logic [1:0]                     in_fwd_last_i;
    logic [1:0]                     in_fwd_ready_and_o;

    logic [1:0][header_width_p-1:0] in_rev_header_o;
    logic [1:0][data_width_p-1:0]   in_rev_data_o;
    logic [1:0]                     in_rev_v_o;
    logic [1:0]                     in_rev_last_o;
    logic [1:0]                     in_rev_ready_and_i;

    logic [header_width_p-1:0]      out_fwd_header_o;
    logic [data_width_p-1:0]        out_fwd_data_o;
    logic                           out_fwd_v_o;
    logic                           out_fwd_last_o;
    logic                           out_fwd_ready_and_i;

    logic [header_width_p-1:0]      out_rev_header_i;
    logic [data_width_p-1:0]        out_rev_data_i;
    logic                           out_rev_v_i;
    logic                           out_rev_last_i;
    logic                           out_rev_ready_and_o;

    modport master (
        output in_fwd_header_i, in_fwd_data_i, in_fwd_v_i, in_fwd_last_i,
        input  in_fwd_ready_and_o,
        input  in_rev_header_o, in_rev_data_o, in_rev_v_o, in_rev_last_o,
        output in_rev_ready_and_i,
        input  out_fwd_header_o, out_fwd_data_o, out_fwd_v_o, out_fwd_last_o,
        output out_fwd_ready_and_i,
        output out_rev_header_i, out_rev_data_i, out_rev_v_i, out_rev_last_i,
        input  out_rev_ready_and_o
    );

    modport slave (
        input  in_fwd_header_i, in_fwd_data_i, in_fwd_v_i, in_fwd_last_i,
        output in_fwd_ready_and_o,
        output in_rev_header_o, in_rev_data_o, in_rev_v_o, in_rev_last_o,
        input  in_rev_ready_and_i,
        output out_fwd_header_o, out_fwd_data_o, out_fwd_v_o, out_fwd_last_o,
        input  out_fwd_ready_and_i,
        input  out_rev_header_i, out_rev_data_i, out_rev_v_i, out_rev_last_i,
        output out_rev_ready_and_o
    );
endinterface

// File: rtl/bsg_chip_mem_fwd_merge.sv
// Merges I$/D$ BedRock streams per message (round-robin, or port 1 fixed priority with BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN); responses steered in order.
// Latency: zero cycles on both request and response paths.
// Backpressure: granted port stalls on out_fwd ready; full source FIFO blocks new grants; responses stall on the head port's ready.
module bsg_chip_mem_fwd_merge #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int els_p          = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    bsg_chip_mem_fwd_merge_if.slave        bus,
    output logic                           err_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} state_e;

    state_e                 state_q, state_d;
    logic                   init_q, init_d;
    logic                   err_q, err_d;
    logic [els_p-1:0]       src_mem_q, src_mem_d;
    logic [ptr_w_lp-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;

    logic fifo_full, fifo_empty, head;
    logic winner, sel, grant_v, fwd_fire, push;
    logic rev_v, rev_rdy, rev_fire, pop;

`ifndef BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN
    logic rr_q, rr_d;
`endif

    assign fifo_full  = (cnt_q == full_cnt_lp);
    assign fifo_empty = (cnt_q == '0);
    assign head       = src_mem_q[rptr_q];

    // Outputs stay quiet until the first clock edge after reset release.
    assign init_d = 1'b1;

    always_comb begin
        winner = bus.in_fwd_v_i[1];
`ifndef BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN
        if (&bus.in_fwd_v_i) begin
            winner = rr_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        sel     = winner;
        grant_v = 1'b0;
        case (state_q)
            S_IDLE:  grant_v = init_q && !fifo_full && (|bus.in_fwd_v_i);
            S_LOCK0: begin
                sel     = 1'b0;
                grant_v = init_q && bus.in_fwd_v_i[0];
            end
            S_LOCK1: begin
                sel     = 1'b1;
                grant_v = init_q && bus.in_fwd_v_i[1];
            end
            default: begin
                sel     = 1'b0;
                grant_v = 1'b0;
            end
        endcase
        fwd_fire = grant_v && bus.out_fwd_ready_and_i;
        push     = fwd_fire && (state_q == S_IDLE);
        if (push && !bus.in_fwd_last_i[sel]) begin
            state_d = sel ? S_LOCK1 : S_LOCK0;
        end else if (fwd_fire && bus.in_fwd_last_i[sel] && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

`ifndef BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN
    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = ~sel;
        end
    end
`endif

    assign bus.out_fwd_v_o        = grant_v;
    assign bus.out_fwd_header_o   = bus.in_fwd_header_i[sel];
    assign bus.out_fwd_data_o     = bus.in_fwd_data_i[sel];
    assign bus.out_fwd_last_o     = bus.in_fwd_last_i[sel];
    assign bus.in_fwd_ready_and_o = {fwd_fire & sel, fwd_fire & ~sel};

    // With nothing outstanding the beat is swallowed and flagged as an error.
    always_comb begin
        rev_v    = init_q && bus.out_rev_v_i && !fifo_empty;
        rev_rdy  = init_q && (fifo_empty || bus.in_rev_ready_and_i[head]);
        rev_fire = bus.out_rev_v_i && rev_rdy;
        pop      = rev_fire && !fifo_empty && bus.out_rev_last_i;
        err_d    = err_q || (rev_fire && fifo_empty);
    end

    assign bus.out_rev_ready_and_o = rev_rdy;
    assign bus.in_rev_v_o          = {rev_v & head, rev_v & ~head};
    assign bus.in_rev_last_o       = {bus.out_rev_last_i & head, bus.out_rev_last_i & ~head};
    assign bus.in_rev_header_o     = {2{bus.out_rev_header_i}};
    assign bus.in_rev_data_o       = {2{bus.out_rev_data_i}};
    assign err_o                   = err_q;

    always_comb begin
        src_mem_d = src_mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        if (push) begin
            src_mem_d[wptr_q] = sel;
            wptr_d            = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            err_q     <= 1'b0;
            src_mem_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            err_q     <= err_d;
            src_mem_q <= src_mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

`ifndef BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif
endmodule

// File: tb/tb_bsg_chip_mem_fwd_merge.sv
// Bench for bsg_chip_mem_fwd_merge: directed scenarios plus a randomized run against a per-port beat/response model.
module tb_bsg_chip_mem_fwd_merge;
    localparam int hw  = 64;
    localparam int dw  = 64;
    localparam int els = 4;

    typedef struct packed {
        logic [hw-1:0] hdr;
        logic [dw-1:0] dat;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bsg_chip_mem_fwd_merge_if #(.header_width_p(hw), .data_width_p(dw)) bus ();

    bsg_chip_mem_fwd_merge #(.header_width_p(hw), .data_width_p(dw), .els_p(els)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus),
        .err_o     (err)
    );

    task automatic idle_inputs();
        bus.in_fwd_header_i     = '0;
        bus.in_fwd_data_i       = '0;
        bus.in_fwd_v_i          = '0;
        bus.in_fwd_last_i       = '0;
        bus.in_rev_ready_and_i  = '0;
        bus.out_fwd_ready_and_i = 1'b0;
        bus.out_rev_header_i    = '0;
        bus.out_rev_data_i      = '0;
        bus.out_rev_v_i         = 1'b0;
        bus.out_rev_last_i      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        bus.in_fwd_v_i = 2'b11;
        bus.in_fwd_last_i = 2'b11;
        bus.out_fwd_ready_and_i = 1'b1;
        bus.out_rev_v_i = 1'b1;
        bus.out_rev_last_i = 1'b1;
        bus.in_rev_ready_and_i = 2'b11;
        step();
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            n_checks++; if (bus.out_fwd_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_fwd_v ph%0d: got %b want 0", ph, bus.out_fwd_v_o); end
            n_checks++; if (bus.in_fwd_ready_and_o !== 2'b00) begin n_fail++; $display("FAIL reset_in_fwd_ready ph%0d: got %b want 00", ph, bus.in_fwd_ready_and_o); end
            n_checks++; if (bus.in_rev_v_o !== 2'b00) begin n_fail++; $display("FAIL reset_in_rev_v ph%0d: got %b want 00", ph, bus.in_rev_v_o); end
            n_checks++; if (bus.out_rev_ready_and_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_rev_ready ph%0d: got %b want 0", ph, bus.out_rev_ready_and_o); end
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err ph%0d: got %b want 0", ph, err); end
            @(posedge clk);
            #1;
            reset_n = 1'b1;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_alternate();
        int exp_src[$];
        int exp;
        apply_reset();
        bus.in_fwd_v_i = 2'b11;
        bus.in_fwd_last_i = 2'b11;
        bus.in_fwd_header_i[0] = 64'hA0A0_0000_0000_0000;
        bus.in_fwd_header_i[1] = 64'hB1B1_0000_0000_0001;
        bus.out_fwd_ready_and_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN
            exp = 1;
`else
            exp = i % 2;
`endif
            n_checks++; if (bus.in_fwd_ready_and_o !== (exp == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_grant[%0d]: got %b want port %0d", i, bus.in_fwd_ready_and_o, exp); end
            n_checks++; if (bus.out_fwd_header_o !== (exp == 1 ? 64'hB1B1_0000_0000_0001 : 64'hA0A0_0000_0000_0000)) begin n_fail++; $display("FAIL alt_hdr[%0d]: got %h want port %0d header", i, bus.out_fwd_header_o, exp); end
            exp_src.push_back(exp);
            step();
        end
        @(negedge clk);
        n_checks++; if (bus.out_fwd_v_o !== 1'b0) begin n_fail++; $display("FAIL alt_full_v: got %b want 0", bus.out_fwd_v_o); end
        step();
        bus.in_fwd_v_i = 2'b00;
        bus.out_rev_v_i = 1'b1;
        bus.out_rev_last_i = 1'b1;
        bus.in_rev_ready_and_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.out_rev_header_i = 64'(i + 16);
            @(negedge clk);
            n_checks++; if (bus.in_rev_v_o !== (exp_src[i] == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_rsp_route[%0d]: got %b want port %0d", i, bus.in_rev_v_o, exp_src[i]); end
            n_checks++; if (bus.in_rev_header_o[exp_src[i]] !== 64'(i + 16)) begin n_fail++; $display("FAIL alt_rsp_hdr[%0d]: got %h want %h", i, bus.in_rev_header_o[exp_src[i]], i + 16); end
            step();
        end
        bus.out_rev_v_i = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL alt_err: got %b want 0", err); end
        idle_inputs();
    endtask

`ifndef BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN
    task automatic test_burst();
        apply_reset();
        bus.out_fwd_ready_and_i = 1'b1;
        bus.in_fwd_v_i = 2'b11;
        bus.in_fwd_header_i[0] = 64'hAAAA;
        bus.in_fwd_header_i[1] = 64'hBBBB;
        bus.in_fwd_last_i[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_fwd_data_i[0] = 64'(100 + k);
            bus.in_fwd_last_i[0] = (k == 3);
            @(negedge clk);
            n_checks++; if (bus.in_fwd_ready_and_o !== 2'b01) begin n_fail++; $display("FAIL burst_grant[%0d]: got %b want 01", k, bus.in_fwd_ready_and_o); end
            n_checks++; if (bus.out_fwd_data_o !== 64'(100 + k) || bus.out_fwd_last_o !== (k == 3)) begin n_fail++; $display("FAIL burst_beat[%0d]: got %0d/%b want %0d/%b", k, bus.out_fwd_data_o, bus.out_fwd_last_o, 100 + k, k == 3); end
            step();
        end
        bus.in_fwd_data_i[0] = 64'd200;
        bus.in_fwd_last_i[0] = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_fwd_ready_and_o !== 2'b10) begin n_fail++; $display("FAIL burst_next_grant: got %b want 10", bus.in_fwd_ready_and_o); end
        n_checks++; if (bus.out_fwd_header_o !== 64'hBBBB) begin n_fail++; $display("FAIL burst_next_hdr: got %h want bbbb", bus.out_fwd_header_o); end
        step();
        idle_inputs();
    endtask
`else
    task automatic test_fixed_prio();
        apply_reset();
        bus.out_fwd_ready_and_i = 1'b1;
        bus.in_fwd_v_i = 2'b11;
        bus.in_fwd_last_i = 2'b11;
        for (int k = 0; k < els; k++) begin
            @(negedge clk);
            n_checks++; if (bus.in_fwd_ready_and_o !== 2'b10) begin n_fail++; $display("FAIL fixed_grant[%0d]: got %b want 10", k, bus.in_fwd_ready_and_o); end
            step();
        end
        idle_inputs();
    endtask
`endif

    task automatic test_full();
        int accepted = 0;
        apply_reset();
        bus.out_fwd_ready_and_i = 1'b1;
        bus.in_fwd_v_i = 2'b01;
        bus.in_fwd_last_i = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.in_fwd_ready_and_o[0] === 1'b1) accepted++;
            if (i >= els) begin
                n_checks++; if (bus.in_fwd_ready_and_o !== 2'b00) begin n_fail++; $display("FAIL full_blocked[%0d]: got %b want 00", i, bus.in_fwd_ready_and_o); end
            end
            step();
        end
        n_checks++; if (accepted != els) begin n_fail++; $display("FAIL full_accepted: got %0d want %0d", accepted, els); end
        bus.out_rev_v_i = 1'b1;
        bus.out_rev_last_i = 1'b1;
        bus.in_rev_ready_and_i = 2'b01;
        @(negedge clk);
        n_checks++; if (bus.out_rev_ready_and_o !== 1'b1 || bus.in_rev_v_o !== 2'b01) begin n_fail++; $display("FAIL full_pop: got rdy %b v %b want 1/01", bus.out_rev_ready_and_o, bus.in_rev_v_o); end
        n_checks++; if (bus.in_fwd_ready_and_o !== 2'b00) begin n_fail++; $display("FAIL full_pop_same_cycle_grant: got %b want 00", bus.in_fwd_ready_and_o); end
        step();
        bus.out_rev_v_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.in_fwd_ready_and_o !== 2'b01) begin n_fail++; $display("FAIL full_fifth: got %b want 01", bus.in_fwd_ready_and_o); end
        step();
        idle_inputs();
    endtask

    task automatic test_hold();
        apply_reset();
        bus.out_fwd_ready_and_i = 1'b1;
        bus.in_fwd_v_i = 2'b10;
        bus.in_fwd_last_i = 2'b10;
        @(negedge clk);
        n_checks++; if (bus.in_fwd_ready_and_o !== 2'b10) begin n_fail++; $display("FAIL hold_req: got %b want 10", bus.in_fwd_ready_and_o); end
        step();
        idle_inputs();
        bus.out_rev_v_i = 1'b1;
        bus.out_rev_last_i = 1'b1;
        bus.out_rev_data_i = 64'd77;
        bus.in_rev_ready_and_i = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (bus.out_rev_ready_and_o !== 1'b0) begin n_fail++; $display("FAIL hold_rdy[%0d]: got %b want 0", c, bus.out_rev_ready_and_o); end
            n_checks++; if (bus.in_rev_v_o !== 2'b10 || bus.in_rev_data_o[1] !== 64'd77) begin n_fail++; $display("FAIL hold_v[%0d]: got %b/%0d want 10/77", c, bus.in_rev_v_o, bus.in_rev_data_o[1]); end
            step();
        end
        bus.in_rev_ready_and_i = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.out_rev_ready_and_o !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %b want 1", bus.out_rev_ready_and_o); end
        step();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL hold_err: got %b want 0", err); end
    endtask

    task automatic test_err();
        apply_reset();
        bus.out_rev_v_i = 1'b1;
        bus.out_rev_last_i = 1'b1;
        bus.in_rev_ready_and_i = 2'b00;
        @(negedge clk);
        n_checks++; if (bus.out_rev_ready_and_o !== 1'b1 || bus.in_rev_v_o !== 2'b00) begin n_fail++; $display("FAIL err_discard: got rdy %b v %b want 1/00", bus.out_rev_ready_and_o, bus.in_rev_v_o); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", err); end
        step();
        bus.out_rev_v_i = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        repeat (3) step();
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear: got %b want 0", err); end
        step();
    endtask

    task automatic test_random();
        beat_t pq0[$];
        beat_t pq1[$];
        beat_t b;
        beat_t got;
        int    exp_rsp[$];
        int    locked = -1;
        int    rsp_left = 0;
        int    p;
        int    len;
        bit    done = 0;
        apply_reset();
        for (int port = 0; port < 2; port++) begin
            for (int m = 0; m < 15; m++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    b.hdr  = {8'(port), 8'(m), 16'(k), $urandom};
                    b.dat  = {$urandom, $urandom};
                    b.last = (k == len - 1);
                    if (port == 0) pq0.push_back(b); else pq1.push_back(b);
                end
            end
        end
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            bus.in_fwd_v_i = 2'b00;
            bus.in_fwd_header_i = {$urandom, $urandom, $urandom, $urandom};
            bus.in_fwd_data_i = {$urandom, $urandom, $urandom, $urandom};
            bus.in_fwd_last_i = 2'($urandom_range(3));
            if (pq0.size() > 0 && $urandom_range(3) != 0) begin
                bus.in_fwd_v_i[0] = 1'b1;
                {bus.in_fwd_header_i[0], bus.in_fwd_data_i[0], bus.in_fwd_last_i[0]} = pq0[0];
            end
            if (pq1.size() > 0 && $urandom_range(3) != 0) begin
                bus.in_fwd_v_i[1] = 1'b1;
                {bus.in_fwd_header_i[1], bus.in_fwd_data_i[1], bus.in_fwd_last_i[1]} = pq1[0];
            end
            bus.out_fwd_ready_and_i = ($urandom_range(3) != 0);
            bus.in_rev_ready_and_i = 2'($urandom_range(3));
            bus.out_rev_v_i = 1'b0;
            if (exp_rsp.size() > 0) begin
                if (rsp_left == 0) rsp_left = $urandom_range(1, 2);
                bus.out_rev_v_i = ($urandom_range(3) != 0);
                bus.out_rev_last_i = (rsp_left == 1);
                bus.out_rev_header_i = {$urandom, $urandom};
                bus.out_rev_data_i = {$urandom, $urandom};
            end
            @(negedge clk);
            n_checks++; if ((bus.in_fwd_ready_and_o & ~bus.in_fwd_v_i) !== 2'b00) begin n_fail++; $display("FAIL rnd_ready_no_valid cyc%0d: ready %b valid %b", cyc, bus.in_fwd_ready_and_o, bus.in_fwd_v_i); end
            if (bus.out_fwd_v_o === 1'b1 && bus.out_fwd_ready_and_i === 1'b1) begin
                n_checks++;
                if ($countones(bus.in_fwd_ready_and_o) != 1) begin
                    n_fail++; $display("FAIL rnd_grant_onehot cyc%0d: got %b want one port", cyc, bus.in_fwd_ready_and_o);
                end else begin
                    p = bus.in_fwd_ready_and_o[1] ? 1 : 0;
                    got = {bus.out_fwd_header_o, bus.out_fwd_data_o, bus.out_fwd_last_o};
                    b = (p == 0) ? pq0[0] : pq1[0];
                    if (p == 0) void'(pq0.pop_front()); else void'(pq1.pop_front());
                    n_checks++; if (locked >= 0 && p != locked) begin n_fail++; $display("FAIL rnd_interleave cyc%0d: got port %0d want %0d", cyc, p, locked); end
                    n_checks++; if (got !== b) begin n_fail++; $display("FAIL rnd_beat cyc%0d port%0d: got %h want %h", cyc, p, got, b); end
                    if (locked < 0) exp_rsp.push_back(p);
                    n_checks++; if (exp_rsp.size() > els) begin n_fail++; $display("FAIL rnd_outstanding cyc%0d: got %0d want <=%0d", cyc, exp_rsp.size(), els); end
                    locked = b.last ? -1 : p;
                end
            end
            if (bus.out_rev_v_i === 1'b1) begin
                p = exp_rsp[0];
                n_checks++; if (bus.in_rev_v_o !== (p == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rnd_rsp_route cyc%0d: got %b want port %0d", cyc, bus.in_rev_v_o, p); end
                n_checks++; if (bus.out_rev_ready_and_o !== bus.in_rev_ready_and_i[p]) begin n_fail++; $display("FAIL rnd_rsp_ready cyc%0d: got %b want %b", cyc, bus.out_rev_ready_and_o, bus.in_rev_ready_and_i[p]); end
                if (bus.out_rev_ready_and_o === 1'b1) begin
                    n_checks++; if (bus.in_rev_header_o[p] !== bus.out_rev_header_i || bus.in_rev_last_o[p] !== bus.out_rev_last_i) begin n_fail++; $display("FAIL rnd_rsp_beat cyc%0d: got %h want %h", cyc, bus.in_rev_header_o[p], bus.out_rev_header_i); end
                    rsp_left--;
                    if (rsp_left == 0) void'(exp_rsp.pop_front());
                end
            end
            done = (pq0.size() == 0) && (pq1.size() == 0) && (exp_rsp.size() == 0);
            step();
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL rnd_complete: pending %0d/%0d beats %0d responses want 0", pq0.size(), pq1.size(), exp_rsp.size()); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b want 0", err); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alternate();
`ifndef BSG_CHIP_MEM_MERGE_FIXED_PRIO_EN
        test_burst();
`else
        test_fixed_prio();
`endif
        test_full();
        test_hold();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
